fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu16_pkg.sv | 29 ++
 rtl/fetch_next_pc.sv | 53 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared cpu16 encodings: PC source, branch type, opcode field, fetch FSM states.
// Fetch syscall behaviour is selected with FETCH_SYSCALL_HALT_EN.
package cpu16_pkg;

  localparam int OP_W   = 5;
  localparam int OP_LSB = 11;

  typedef enum logic [1:0] {
    PC_SEQ     = 2'b00,
    PC_JUMP    = 2'b01,
    PC_JR      = 2'b10,
    PC_SYSCALL = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_Z    = 2'b01,
    BR_GTZ  = 2'b10,
    BR_LTZ  = 2'b11
  } brtype_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC and branch-condition evaluation for the held instruction.
// FETCH_SYSCALL_HALT_EN: syscall falls through to pc+1 instead of SYSCALL_VEC.
module fetch_next_pc
  import cpu16_pkg::*;
#(
  parameter logic [15:0] SYSCALL_VEC = 16'h0010
) (
  input  logic [15:0] pc_i,
  input  logic [10:0] imm_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [1:0]  brtype_i,
  input  logic [15:0] rs_val_i,
  output logic [15:0] next_pc_o
);

  logic [15:0] seq_pc;
  logic [15:0] br_off;
  logic        taken;

  assign seq_pc = pc_i + 16'd1;
  assign br_off = {{8{imm_i[7]}}, imm_i[7:0]};

  always_comb begin
    taken = 1'b0;
    unique case (brtype_e'(brtype_i))
      BR_Z:    taken = (rs_val_i == 16'h0000);
      BR_GTZ:  taken = !rs_val_i[15] && (rs_val_i != 16'h0000);
      BR_LTZ:  taken = rs_val_i[15];
      default: taken = 1'b0;
    endcase
  end

`ifdef FETCH_SYSCALL_HALT_EN
  logic [15:0] unused_vec;
  assign unused_vec = SYSCALL_VEC;
`endif

  // A non-sequential pcsrc always wins over any branch condition.
  always_comb begin
    next_pc_o = seq_pc;
    unique case (pcsrc_e'(pcsrc_i))
      PC_JUMP: next_pc_o = {pc_i[15:11], imm_i};
      PC_JR:   next_pc_o = rs_val_i;
`ifdef FETCH_SYSCALL_HALT_EN
      PC_SYSCALL: next_pc_o = seq_pc;
`else
      PC_SYSCALL: next_pc_o = SYSCALL_VEC;
`endif
      default: next_pc_o = taken ? seq_pc + br_off : seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// cpu16 instruction fetch: request/ack memory port, one held instruction slot.
// FETCH_SYSCALL_HALT_EN: syscall stops fetch in HALT until resume.
module fetch_unit
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] SYSCALL_VEC = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [4:0]  op,
  output logic [15:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pcsrc,
  input  logic [1:0]  brtype,
  input  logic [15:0] rs_val,
  input  logic        resume,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [15:0] next_pc;
  logic        halt_go;
  logic        resume_go;

  fetch_next_pc #(
    .SYSCALL_VEC(SYSCALL_VEC)
  ) u_next_pc (
    .pc_i     (pc_out_q),
    .imm_i    (instr_q[10:0]),
    .pcsrc_i  (pcsrc),
    .brtype_i (brtype),
    .rs_val_i (rs_val),
    .next_pc_o(next_pc)
  );

`ifdef FETCH_SYSCALL_HALT_EN
  assign halt_go   = (pcsrc_e'(pcsrc) == PC_SYSCALL);
  assign resume_go = resume;
  assign halted    = (state_q == ST_HALT);
`else
  logic unused_resume;
  assign unused_resume = resume;
  assign halt_go   = 1'b0;
  assign resume_go = 1'b1;
  assign halted    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = halt_go ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (resume_go) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      pc_out_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_LSB +: OP_W];
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a zero-wait memory model.
// Honours FETCH_SYSCALL_HALT_EN for the syscall sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [4:0]  op;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pcsrc;
  logic [1:0]  brtype;
  logic [15:0] rs_val;
  logic        resume;
  logic        halted;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .pc_out     (pc_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pcsrc      (pcsrc),
    .brtype     (brtype),
    .rs_val     (rs_val),
    .resume     (resume),
    .halted     (halted)
  );

  typedef struct {
    logic [15:0] word;
    logic [1:0]  pcsrc;
    logic [1:0]  brtype;
    logic [15:0] rs;
    logic [15:0] addr;
    logic [4:0]  op;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) step();
    if (imem_req !== 1'b1) begin
      n_total++;
      $display("FAIL %s: imem_req timeout got 0 expected 1", name);
    end
  endtask

  task automatic junk_ctrl();
    pcsrc  = 2'b10;
    brtype = 2'b11;
    rs_val = 16'hDEAD;
  endtask

  task automatic ack_word(input logic [15:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'hA5A5;
  endtask

  task automatic accept(input logic [1:0] ps, input logic [1:0] bt,
                        input logic [15:0] rs);
    instr_ready = 1'b1;
    pcsrc       = ps;
    brtype      = bt;
    rs_val      = rs;
    step();
    instr_ready = 1'b0;
    junk_ctrl();
  endtask

  task automatic fetch_one(input string name, input vec_t v);
    wait_req(name);
    chk({name, ".addr"}, 64'(imem_addr), 64'(v.addr));
    ack_word(v.word);
    chk({name, ".valid"}, 64'(instr_valid), 64'd1);
    chk({name, ".instr"}, 64'(instr), 64'(v.word));
    chk({name, ".op"}, 64'(op), 64'(v.op));
    chk({name, ".pc_out"}, 64'(pc_out), 64'(v.addr));
    accept(v.pcsrc, v.brtype, v.rs);
  endtask

  initial begin
    vec_t tmp;
    vecs[0]  = '{16'h0000, 2'b00, 2'b00, 16'h0000, 16'h0000, 5'h00};
    vecs[1]  = '{16'h0000, 2'b00, 2'b00, 16'h0000, 16'h0001, 5'h00};
    vecs[2]  = '{16'h0000, 2'b00, 2'b00, 16'h0000, 16'h0002, 5'h00};
    vecs[3]  = '{16'h0820, 2'b01, 2'b00, 16'h0000, 16'h0003, 5'h01};
    vecs[4]  = '{16'h10FE, 2'b00, 2'b11, 16'h8000, 16'h0020, 5'h02};
    vecs[5]  = '{16'h0820, 2'b01, 2'b00, 16'h0000, 16'h001F, 5'h01};
    vecs[6]  = '{16'h10FE, 2'b00, 2'b11, 16'h0001, 16'h0020, 5'h02};
    vecs[7]  = '{16'h1803, 2'b00, 2'b10, 16'h7FFF, 16'h0021, 5'h03};
    vecs[8]  = '{16'h1803, 2'b00, 2'b10, 16'h8000, 16'h0025, 5'h03};
    vecs[9]  = '{16'h2010, 2'b00, 2'b01, 16'h0000, 16'h0026, 5'h04};
    vecs[10] = '{16'h2010, 2'b00, 2'b01, 16'h0005, 16'h0037, 5'h04};
    vecs[11] = '{16'h0840, 2'b01, 2'b11, 16'h8000, 16'h0038, 5'h01};
    vecs[12] = '{16'h1800, 2'b10, 2'b00, 16'hFFFF, 16'h0040, 5'h03};
    vecs[13] = '{16'h0000, 2'b00, 2'b00, 16'h0000, 16'hFFFF, 5'h00};

    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 16'hA5A5;
    instr_ready = 1'b0;
    resume      = 1'b0;
    junk_ctrl();
    step();
    step();
    chk("reset.state", {imem_req, instr_valid, halted, instr, pc_out},
        {3'b000, 16'h0000, 16'h0000});
    rst = 1'b0;
    chk("reset.release_idle", 64'(imem_req), 64'd0);

    for (int i = 0; i < 14; i++)
      fetch_one($sformatf("vec%0d", i), vecs[i]);

    // stall in HOLD
    wait_req("stall");
    chk("stall.addr", 64'(imem_addr), 64'h0000);
    ack_word(16'h1234);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d", i),
          {imem_req, instr_valid, op, instr, pc_out},
          {1'b0, 1'b1, 5'h02, 16'h1234, 16'h0000});
      step();
    end
    accept(2'b00, 2'b00, 16'h0000);

    // syscall
    wait_req("sys");
    chk("sys.addr", 64'(imem_addr), 64'h0001);
    ack_word(16'hF800);
    accept(2'b11, 2'b00, 16'h0000);
`ifdef FETCH_SYSCALL_HALT_EN
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("halt%0d", i), {imem_req, halted, instr_valid},
          {1'b0, 1'b1, 1'b0});
      step();
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume", {imem_req, halted, imem_addr}, {1'b1, 1'b0, 16'h0002});
    tmp = '{16'h5555, 2'b00, 2'b00, 16'h0000, 16'h0002, 5'h0A};
`else
    chk("sys.halted", 64'(halted), 64'd0);
    tmp = '{16'h5555, 2'b00, 2'b00, 16'h0000, 16'h0010, 5'h0A};
`endif
    fetch_one("post_sys", tmp);

    // reset mid-FETCH with a late ack
    wait_req("rstmid");
    rst = 1'b1;
    #1;
    chk("rstmid.async", {imem_req, instr_valid, halted, instr, pc_out},
        {3'b000, 16'h0000, 16'h0000});
    step();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'hA5A5;
    chk("rstmid.ignored", {imem_req, instr_valid, instr, imem_addr},
        {1'b1, 1'b0, 16'h0000, 16'h0000});
    tmp = '{16'hF801, 2'b00, 2'b00, 16'h0000, 16'h0000, 5'h1F};
    fetch_one("rstmid.fetch", tmp);
    wait_req("final");
    chk("final.addr", 64'(imem_addr), 64'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
